// File: rtl/fu_issue_arbiter.sv
// fu_issue_arbiter
//
// Round-robin issue arbiter that shares one non-pipelined functional unit
// (for example a divider) among N_REQ reservation-station requesters.
// At most one requester is granted per cycle. After a grant, the FU stays
// occupied for the granted request's latency, and no further grant is
// issued until it is free again.
//
// Handshake: req[i] is a valid-style request that the requester holds
// until it sees gnt[i]. gnt[i] is the ready/accept for that cycle. A
// transfer happens on a rising edge where req[i] and gnt[i] are both high.
// A requester may drop req at any time while not granted.
//
// Ports:
//   clk        system clock, rising-edge state updates
//   rst_n      asynchronous active-low reset
//   req        request vector, bit i = requester i ready to issue
//   req_lat    occupancy cycles of requester i at [i*LAT_W +: LAT_W]
//   flush      synchronous pipeline flush, cancels occupancy, blocks grant
//   gnt        one-hot grant, combinational
//   gnt_valid  OR of gnt
//   gnt_idx    index of the granted requester, 0 when no grant
//   busy       FU occupied (busy_cnt != 0), no grant this cycle
//   busy_cnt   remaining blocked cycles (registered); also the FSM state:
//              zero means FREE, nonzero means BUSY
module fu_issue_arbiter #(
    parameter int N_REQ = 4,
    parameter int LAT_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*LAT_W-1:0]   req_lat,
    input  logic                     flush,
    output logic [N_REQ-1:0]         gnt,
    output logic                     gnt_valid,
    output logic [$clog2(N_REQ)-1:0] gnt_idx,
    output logic                     busy,
    output logic [LAT_W-1:0]         busy_cnt
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [LAT_W-1:0] busy_cnt_q, busy_cnt_d;

    logic [N_REQ-1:0] rot_req;
    logic [IDX_W-1:0] sel_off;
    logic             sel_found;
    logic             can_grant;
    logic [LAT_W-1:0] lat_sel;
    logic [LAT_W-1:0] lat_eff;

    // Rotate the request vector so that bit 0 is the requester at ptr. The
    // lowest set bit of the rotated vector is then the first requester at
    // or after ptr. Index arithmetic wraps naturally because N_REQ is a
    // power of two.
    always_comb begin
        rot_req = '0;
        for (int j = 0; j < N_REQ; j++) begin
            rot_req[j] = req[ptr_q + IDX_W'(j)];
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_off   = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!sel_found && rot_req[j]) begin
                sel_found = 1'b1;
                sel_off   = IDX_W'(j);
            end
        end
    end

    // Reset is included here so that outputs are quiet while reset is held,
    // even though the registered state is already cleared.
    always_comb begin
        can_grant = rst_n && !flush && (busy_cnt_q == '0);
        gnt_valid = can_grant && sel_found;
        gnt_idx   = gnt_valid ? (ptr_q + sel_off) : '0;
        gnt       = gnt_valid ? (N_REQ'(1) << gnt_idx) : '0;
    end

    // A latency of 0 is treated as 1, so the unit still takes the edge.
    always_comb begin
        lat_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IDX_W'(i) == gnt_idx) begin
                lat_sel = req_lat[i*LAT_W +: LAT_W];
            end
        end
        lat_eff = (lat_sel == '0) ? LAT_W'(1) : lat_sel;
    end

    // Next state: flush dominates, then BUSY countdown, then a new grant.
    always_comb begin
        ptr_d      = ptr_q;
        busy_cnt_d = busy_cnt_q;
        if (flush) begin
            busy_cnt_d = '0;
        end else if (busy_cnt_q != '0) begin
            busy_cnt_d = busy_cnt_q - LAT_W'(1);
        end else if (gnt_valid) begin
            busy_cnt_d = lat_eff - LAT_W'(1);
            ptr_d      = gnt_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            busy_cnt_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy     = (busy_cnt_q != '0);
    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Directed bench for fu_issue_arbiter (N_REQ=4, LAT_W=3).
module tb_fu_issue_arbiter;

    localparam int N_REQ = 4;
    localparam int LAT_W = 3;

    logic                   clk;
    logic                   rst_n;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*LAT_W-1:0] req_lat;
    logic                   flush;
    logic [N_REQ-1:0]       gnt;
    logic                   gnt_valid;
    logic [1:0]             gnt_idx;
    logic                   busy;
    logic [LAT_W-1:0]       busy_cnt;

    int errors = 0;
    int checks = 0;

    fu_issue_arbiter #(.N_REQ(N_REQ), .LAT_W(LAT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_lat   (req_lat),
        .flush     (flush),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .busy      (busy),
        .busy_cnt  (busy_cnt)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drivers.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lat(input int i, input logic [LAT_W-1:0] v);
        req_lat[i*LAT_W +: LAT_W] = v;
    endtask

    // Comparison point.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Full output check for a cycle that must grant index g.
    task automatic chk_grant(input string tag, input int g);
        #1;
        chk({tag, " gnt"}, 32'(gnt), 32'(1 << g));
        chk({tag, " idx"}, 32'(gnt_idx), 32'(g));
        chk({tag, " valid"}, 32'(gnt_valid), 32'd1);
        chk({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_none(input string tag, input int exp_cnt);
        #1;
        chk({tag, " gnt"}, 32'(gnt), 32'd0);
        chk({tag, " valid"}, 32'(gnt_valid), 32'd0);
        chk({tag, " idx"}, 32'(gnt_idx), 32'd0);
        chk({tag, " cnt"}, 32'(busy_cnt), 32'(exp_cnt));
        chk({tag, " busy"}, 32'(busy), 32'(exp_cnt != 0));
    endtask

    int fair_seq [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst_n   = 1'b0;
        req     = 4'b1111;
        req_lat = '0;
        flush   = 1'b0;
        for (int i = 0; i < N_REQ; i++) set_lat(i, 3'd1);

        // Reset held with all requesting: outputs quiet.
        cyc();
        chk_none("reset_hold", 0);

        // Fairness: all requesting, latency 1 -> 0,1,2,3,0.
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk_grant($sformatf("fair%0d", k), fair_seq[k]);
            cyc();
        end

        // Wrap-around: ptr=1, only 3 requests -> idx3, ptr wraps to 0.
        req = 4'b1000;
        chk_grant("wrap3", 3);
        cyc();
        req = 4'b1001;
        chk_grant("wrap0", 0);
        cyc();

        // ptr=1 now; grant idx3 to bring ptr back to 0.
        req = 4'b1000;
        chk_grant("realign", 3);
        cyc();

        // Multi-cycle: idx0 latency 3, idx2 latency 1.
        req = 4'b0101;
        set_lat(0, 3'd3);
        chk_grant("multi_t0", 0);
        cyc();
        req = 4'b0100;
        chk_none("multi_t1", 2);
        cyc();
        chk_none("multi_t2", 1);
        cyc();
        chk_grant("multi_t3", 2);
        cyc();

        // ptr=3: grant idx3 with latency 5 -> busy_cnt 4.
        req = 4'b1000;
        set_lat(3, 3'd5);
        chk_grant("pre_flush", 3);
        cyc();
        req = 4'b0010;
        flush = 1'b1;
        chk_none("flush_cycle", 4);
        cyc();
        flush = 1'b0;
        #1;
        chk("post_flush cnt", 32'(busy_cnt), 32'd0);
        chk_grant("post_flush", 1);
        cyc();

        // ptr=2. Zero latency requester 0 for three cycles.
        req = 4'b0001;
        set_lat(0, 3'd0);
        for (int k = 0; k < 3; k++) begin
            chk_grant($sformatf("zero_lat%0d", k), 0);
            chk("zero_lat cnt", 32'(busy_cnt), 32'd0);
            cyc();
        end

        // No requests while free: nothing granted.
        req = 4'b0000;
        chk_none("idle", 0);
        cyc();

        // ptr=1: grant idx1 with latency 3 -> busy_cnt 2, then async reset.
        req = 4'b1111;
        set_lat(1, 3'd3);
        chk_grant("pre_reset", 1);
        cyc();
        chk_none("busy_before_reset", 2);
        #2;
        rst_n = 1'b0;
        chk_none("reset_mid_busy", 0);
        cyc();
        rst_n = 1'b1;
        chk_grant("after_reset", 0);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
